// File: rtl/button_event_fifo.sv
// button_event_fifo: sync + debounce 12 button lines, queue press codes.
// Ports: clk, reset, buttons[11:0] in; held[11:0], ev_valid, ev_code[3:0],
// overflow out; ev_ready in (consumer accepts FIFO head).
module button_event_fifo #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] buttons,
  output logic [11:0] held,
  output logic        ev_valid,
  output logic [3:0]  ev_code,
  input  logic        ev_ready,
  output logic        overflow
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [15:0] DB_LIM   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [11:0]       s1, s2;
  logic [11:0][15:0] cnt, cnt_nx;
  logic [11:0]       held_nx;
  logic [11:0]       rise;
  logic [11:0]       pending, pending_nx;
  logic [11:0]       enq_mask;
  logic              drop;

  logic              enq_found;
  logic [3:0]        enq_idx;
  logic              enq, pop, full;

  logic [3:0]        mem [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [AW:0]       count, count_nx;

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= buttons;
      s2 <= s1;
    end
  end

  // Counter tracks how long s2 has disagreed with held; hitting the
  // limit flips held on that same edge.
  always_comb begin
    held_nx = held;
    cnt_nx  = cnt;
    for (int i = 0; i < 12; i++) begin
      if (s2[i] == held[i]) begin
        cnt_nx[i] = '0;
      end else if (cnt[i] == DB_LIM) begin
        cnt_nx[i]  = '0;
        held_nx[i] = ~held[i];
      end else begin
        cnt_nx[i] = cnt[i] + 16'd1;
      end
    end
  end

  assign rise = held_nx & ~held;

  always_ff @(posedge clk) begin
    if (reset) begin
      held <= '0;
      cnt  <= '0;
    end else begin
      held <= held_nx;
      cnt  <= cnt_nx;
    end
  end

  // Lowest-index pending bit wins the single enqueue slot.
  always_comb begin
    enq_found = 1'b0;
    enq_idx   = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (pending[i] && !enq_found) begin
        enq_found = 1'b1;
        enq_idx   = 4'(i);
      end
    end
  end

  assign pop  = ev_valid & ev_ready;
  assign full = (count == FULL_CNT);
  // A pop frees the slot on the same edge, so full+pop may enqueue.
  assign enq  = enq_found & (~full | pop);

  assign enq_mask = enq ? (12'b1 << enq_idx) : 12'b0;

  // A press is only lost if its pending bit stays occupied this edge.
  assign drop       = |(rise & pending & ~enq_mask);
  assign pending_nx = (pending & ~enq_mask) | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_nx;
      if (drop) overflow <= 1'b1;
    end
  end

  always_comb begin
    count_nx = count;
    unique case ({enq, pop})
      2'b10:   count_nx = count + CNT_ONE;
      2'b01:   count_nx = count - CNT_ONE;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      count <= count_nx;
      if (enq) tail <= tail + PTR_ONE;
      if (pop) head <= head + PTR_ONE;
    end
  end

  // Storage needs no reset; the output is gated by ev_valid.
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= enq_idx;
  end

  assign ev_valid = (count != '0);
  assign ev_code  = ev_valid ? mem[head] : 4'd0;

endmodule
